// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the three-digit seven-segment scan controller.
// Segment bit order is a..g on bits 0..6, active-high.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam int NUM_DIGITS = 3;

  // Standard hex glyphs 0..F, bit0 = segment a.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seven_seg_hex_lut.sv
// Combinational nibble-to-glyph decode for the seven-segment scan controller.
// Only instantiated when SEVEN_SEG_HEX_LUT_EN is defined.
module seven_seg_hex_lut
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_Nibble,
  output logic [6:0] o_Glyph
);

  assign o_Glyph = HEX_GLYPH[i_Nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Three-digit multiplexed seven-segment scan controller with anti-ghost
// blanking, per-slot PWM brightness and a frame-done pulse.
// Optional macro SEVEN_SEG_HEX_LUT_EN adds hex-glyph decode of each digit's
// low nibble, selected per frame by i_HexLutEn.
//
// state | meaning
// IDLE  | scan disabled, display dark, waiting for i_Enable
// BLANK | slot start, all digits dark to avoid ghosting
// DRIVE | current digit driven, enable gated by brightness PWM
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int CLKS_PER_SLOT = 4096,
  parameter int BLANK_CLKS    = 64
)
(
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  input  logic       i_HexLutEn,
  input  logic [3:0] i_Brightness,
  input  logic [6:0] i_SegOne,
  input  logic [6:0] i_SegTwo,
  input  logic [6:0] i_SegThree,
  output logic [2:0] o_7Seg_En,
  output logic [6:0] o_7Seg_Led,
  output logic       o_FrameDone
);

  localparam int CW = (CLKS_PER_SLOT > 2) ? $clog2(CLKS_PER_SLOT) : 1;
  // Down-counter reload values; the phase ends when the counter reads zero.
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CLKS - 1);
  localparam logic [CW-1:0] DRIVE_LOAD = CW'(CLKS_PER_SLOT - BLANK_CLKS - 1);

  state_t      r_state;
  logic [1:0]  r_digit;
  logic [CW-1:0] r_slot_cnt;
  logic [3:0]  r_pwm_cnt;
  logic [6:0]  r_snap_one;
  logic [6:0]  r_snap_two;
  logic [6:0]  r_snap_three;
  logic        r_snap_lut;
  logic [2:0]  r_seg_en;
  logic [6:0]  r_seg_led;
  logic        r_frame_done;

  state_t      w_state_nxt;
  logic [1:0]  w_digit_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]  w_pwm_nxt;
  logic        w_snap_take;
  logic        w_frame_end;
  logic [6:0]  w_seg_sel;
  logic [6:0]  w_disp;
  logic [2:0]  w_en_nxt;
  logic [6:0]  w_led_nxt;

  // State, digit index and counters.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state    <= ST_IDLE;
      r_digit    <= 2'd0;
      r_slot_cnt <= '0;
      r_pwm_cnt  <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_digit    <= w_digit_nxt;
      r_slot_cnt <= w_cnt_nxt;
      r_pwm_cnt  <= w_pwm_nxt;
    end
  end

  // Next-state logic; dropping i_Enable aborts from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_cnt_nxt   = r_slot_cnt;
    w_pwm_nxt   = r_pwm_cnt;
    w_snap_take = 1'b0;
    w_frame_end = 1'b0;
    if (!i_Enable) begin
      w_state_nxt = ST_IDLE;
      w_digit_nxt = 2'd0;
      w_cnt_nxt   = '0;
      w_pwm_nxt   = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_BLANK;
          w_digit_nxt = 2'd0;
          w_cnt_nxt   = BLANK_LOAD;
          w_pwm_nxt   = 4'd0;
          w_snap_take = 1'b1;
        end
        ST_BLANK: begin
          if (r_slot_cnt == '0) begin
            w_state_nxt = ST_DRIVE;
            w_cnt_nxt   = DRIVE_LOAD;
            w_pwm_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_slot_cnt - CW'(1);
          end
        end
        ST_DRIVE: begin
          w_pwm_nxt = r_pwm_cnt + 4'd1;
          if (r_slot_cnt == '0) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = BLANK_LOAD;
            w_pwm_nxt   = 4'd0;
            if (r_digit == 2'd2) begin
              w_digit_nxt = 2'd0;
              w_snap_take = 1'b1;
              w_frame_end = 1'b1;
            end else begin
              w_digit_nxt = r_digit + 2'd1;
            end
          end else begin
            w_cnt_nxt = r_slot_cnt - CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_digit_nxt = 2'd0;
          w_cnt_nxt   = '0;
          w_pwm_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Frame snapshot of digit data and decode mode, taken entering digit 0 BLANK.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_snap_one   <= 7'd0;
      r_snap_two   <= 7'd0;
      r_snap_three <= 7'd0;
      r_snap_lut   <= 1'b0;
    end else if (w_snap_take) begin
      r_snap_one   <= i_SegOne;
      r_snap_two   <= i_SegTwo;
      r_snap_three <= i_SegThree;
      r_snap_lut   <= i_HexLutEn;
    end
  end

  // Select the snapshotted data of the digit being scanned.
  always_comb begin
    w_seg_sel = 7'd0;
    case (r_digit)
      2'd0:    w_seg_sel = r_snap_one;
      2'd1:    w_seg_sel = r_snap_two;
      2'd2:    w_seg_sel = r_snap_three;
      default: w_seg_sel = 7'd0;
    endcase
  end

`ifdef SEVEN_SEG_HEX_LUT_EN
  logic [6:0] w_glyph;

  seven_seg_hex_lut u_hex_lut (
    .i_Nibble (w_seg_sel[3:0]),
    .o_Glyph  (w_glyph)
  );

  assign w_disp = r_snap_lut ? w_glyph : w_seg_sel;
`else
  // Raw segments only; the decode-mode snapshot has no consumer here.
  logic w_unused_lut;
  assign w_unused_lut = r_snap_lut;
  assign w_disp       = w_seg_sel;
`endif

  // Pin decision from the current state; brightness compared live each cycle.
  always_comb begin
    w_en_nxt  = 3'd0;
    w_led_nxt = 7'd0;
    if (i_Enable && (r_state == ST_DRIVE)) begin
      w_led_nxt = w_disp;
      if (r_pwm_cnt <= i_Brightness) begin
        w_en_nxt = 3'b001 << r_digit;
      end
    end
  end

  // Registered pins; async reset darkens the display without waiting for a clock.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_seg_en     <= 3'd0;
      r_seg_led    <= 7'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg_en     <= w_en_nxt;
      r_seg_led    <= w_led_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  assign o_7Seg_En   = r_seg_en;
  assign o_7Seg_Led  = r_seg_led;
  assign o_FrameDone = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl (CLKS_PER_SLOT=16, BLANK_CLKS=4).
// A time-based reference model pushes the expected pins after every rising
// edge; a monitor pops and compares on every falling edge.
module tb_seven_seg_scan_ctrl;

  localparam int CPS   = 16;
  localparam int BLK   = 4;
  localparam int FRAME = 3 * CPS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       hexlut = 1'b0;
  logic [3:0] bright = 4'd0;
  logic [6:0] s1 = 7'd0, s2 = 7'd0, s3 = 7'd0;
  logic [2:0] seg_en;
  logic [6:0] seg_led;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] en;
    logic [6:0] led;
    logic       fd;
  } exp_t;

  exp_t q[$];

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seven_seg_scan_ctrl #(.CLKS_PER_SLOT(CPS), .BLANK_CLKS(BLK)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Enable     (enable),
    .i_HexLutEn   (hexlut),
    .i_Brightness (bright),
    .i_SegOne     (s1),
    .i_SegTwo     (s2),
    .i_SegThree   (s3),
    .o_7Seg_En    (seg_en),
    .o_7Seg_Led   (seg_led),
    .o_FrameDone  (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: scan time t counts edges since the scan started.
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [6:0] m_snap [3];
  bit         m_lut = 1'b0;

  function automatic logic [6:0] shown(input int d);
    logic [6:0] v;
    v = m_snap[d];
`ifdef SEVEN_SEG_HEX_LUT_EN
    if (m_lut) v = glyph[v[3:0]];
`endif
    return v;
  endfunction

  task automatic take_snap();
    m_snap[0] = s1;
    m_snap[1] = s2;
    m_snap[2] = s3;
    m_lut     = hexlut;
  endtask

  initial begin
    exp_t e;
    int   pos, dig, pwm;
    m_snap[0] = 7'd0; m_snap[1] = 7'd0; m_snap[2] = 7'd0;
    forever begin
      @(posedge clk);
      e = '0;
      if (rst) begin
        m_active = 1'b0;
        m_t      = 0;
      end else begin
        if (m_active && enable) begin
          pos = m_t % CPS;
          dig = (m_t / CPS) % 3;
          if (pos >= BLK) begin
            pwm   = (pos - BLK) % 16;
            e.led = shown(dig);
            if (pwm <= int'(bright)) e.en = 3'b001 << dig;
            e.fd  = (dig == 2) && (pos == CPS - 1);
          end
        end
        if (!enable) begin
          m_active = 1'b0;
        end else if (!m_active) begin
          m_active = 1'b1;
          m_t      = 0;
          take_snap();
        end else begin
          m_t++;
          if (m_t % FRAME == 0) take_snap();
        end
      end
      q.push_back(e);
    end
  end

  // Monitor: compare every cycle's pins against the model's expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t: no expected value queued", $time);
      end else begin
        e = q.pop_front();
        if (seg_en !== e.en || seg_led !== e.led || frame_done !== e.fd) begin
          errors++;
          $display("FAIL scan_pins at %0t: en got %b want %b, led got %h want %h, fd got %b want %b",
                   $time, seg_en, e.en, seg_led, e.led, frame_done, e.fd);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit found;
    run(4);
    #2 rst = 1'b0;

    // Raw scan, full brightness.
    s1 = 7'h01; s2 = 7'h02; s3 = 7'h04; bright = 4'd15; hexlut = 1'b0;
    enable = 1'b1;
    run(2 * FRAME + 5);

    // PWM at code 3.
    bright = 4'd3;
    run(FRAME);

    // Restart, then change digit 1 data while digit 0 is still scanning.
    enable = 1'b0; run(2); enable = 1'b1;
    run(7);
    s2 = 7'h55;
    run(2 * FRAME);

    // Hex decode request on digit 0.
    enable = 1'b0; run(2);
    hexlut = 1'b1; s1 = 7'h0A; bright = 4'd15; enable = 1'b1;
    run(FRAME + 5);
    hexlut = 1'b0;

    // Abort during digit 1 DRIVE, then restart.
    enable = 1'b0; run(3); enable = 1'b1;
    run(CPS + BLK + 3);
    enable = 1'b0; run(5); enable = 1'b1;
    run(FRAME + 3);

    // Randomized data, brightness, decode mode and enable drops.
    for (int i = 0; i < 40; i++) begin
      s1 = 7'($urandom); s2 = 7'($urandom); s3 = 7'($urandom);
      bright = 4'($urandom);
      hexlut = 1'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        enable = 1'b0;
        run($urandom_range(1, 5));
        enable = 1'b1;
      end
      run($urandom_range(1, 40));
    end

    // Asynchronous reset in the middle of DRIVE.
    s1 = 7'h7F; s2 = 7'h7F; s3 = 7'h7F; bright = 4'd15;
    found = 1'b0;
    for (int k = 0; k < 4 * FRAME && !found; k++) begin
      @(negedge clk);
      if (seg_led != 7'd0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL drive_wait: no lit digit seen within %0d cycles", 4 * FRAME);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (seg_en !== 3'd0 || seg_led !== 7'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: en %b led %h fd %b, want all zero", seg_en, seg_led, frame_done);
    end
    run(3);
    #2 rst = 1'b0;
    run(FRAME + 5);

    run(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter CLKS_PER_SLOT, default 4096, is the i_Clk cycles per digit slot (blank plus drive); legal range is 2 or more.
REQ-002 Parameter BLANK_CLKS, default 64, is the anti-ghost blank cycles at slot start; legal range is 1 to CLKS_PER_SLOT-1.
REQ-003 Ports, one per line, SHALL be:
  i_Clk  in  1  sole clock, rising edge.
  i_Rst  in  1  reset, asynchronous, active-high.
  i_Enable  in  1  scan enable; 0 forces the display dark.
  i_HexLutEn  in  1  1 selects hex-glyph decode of low nibble; 0 selects raw segments.
  i_Brightness  in  4  PWM duty code.
  i_SegOne / i_SegTwo / i_SegThree  in  7 each  digit 0/1/2 data; bit0=a .. bit6=g.
  o_7Seg_En  out  3  one-hot digit enable, active-high.
  o_7Seg_Led  out  7  segment drive, active-high.
  o_FrameDone  out  1  single-cycle pulse at end of each 3-digit frame.

Function
REQ-004 The FSM SHALL have states IDLE, BLANK and DRIVE, plus a 2-bit digit index (0..2) and a slot counter of $clog2(CLKS_PER_SLOT) bits.
REQ-005 Transitions:
  - IDLE->BLANK (digit 0) when i_Enable=1.
  - BLANK->DRIVE after BLANK_CLKS cycles.
  - DRIVE->BLANK (next digit) after CLKS_PER_SLOT-BLANK_CLKS cycles.
  - Digit index wraps 2->0.
REQ-006 i_Enable=0 in any state SHALL force IDLE on the next edge and reset the digit index and counters to 0.
REQ-007 All three i_Seg* values and i_HexLutEn SHALL be snapshotted on entry to BLANK of digit 0; mid-frame input changes are not displayed until the next frame.
REQ-008 In IDLE and BLANK, o_7Seg_En and o_7Seg_Led SHALL be all zero.
REQ-009 In DRIVE, a 4-bit PWM counter SHALL be cleared on DRIVE entry and increment every cycle, wrapping 15->0.
REQ-010 In DRIVE, o_7Seg_En[digit] SHALL be 1 only while pwm_cnt <= i_Brightness, so code 0 gives 1/16 duty and code 15 is always on.
REQ-011 o_7Seg_Led SHALL carry the snapshotted segment data of the current digit for the whole DRIVE phase, independent of PWM.
REQ-012 All outputs SHALL be registered: pins reflect the state/PWM decision of the previous cycle (1-cycle latency).
REQ-013 o_FrameDone SHALL pulse for exactly one cycle, coincident with the DRIVE->BLANK transition from digit 2.
REQ-014 o_FrameDone SHALL not pulse when a frame is aborted by i_Enable=0.
REQ-015 i_Brightness SHALL be sampled live, with no snapshot.

Reset
REQ-016 While i_Rst=1, the block SHALL hold:
  - state IDLE, digit 0, all counters 0, snapshots 0;
  - o_7Seg_En=0, o_7Seg_Led=0, o_FrameDone=0.
REQ-017 After i_Rst deasserts, the first edge with i_Enable=1 SHALL enter BLANK for digit 0.
REQ-018 Reset asserted mid-frame SHALL blank the outputs immediately (asynchronously), not waiting for a clock edge.

Configuration
REQ-019 Macro SEVEN_SEG_HEX_LUT_EN defined: when the snapshotted i_HexLutEn=1, each digit displays the standard 0-F glyph of its i_Seg*[3:0] and bits [6:4] are ignored.
REQ-020 Macro SEVEN_SEG_HEX_LUT_EN undefined: i_HexLutEn is ignored, raw i_Seg* bits are always driven, and no LUT logic is synthesized.

Structure
REQ-021 Package seven_seg_pkg SHALL hold:
  - the FSM state enum;
  - the segment bit-order constants;
  - the 16-entry hex glyph table (0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F,0x77,0x7C,0x39,0x5E,0x79,0x71).
REQ-022 Sub-module seven_seg_hex_lut (combinational nibble-to-glyph) SHALL be instantiated only under SEVEN_SEG_HEX_LUT_EN.

Verification (CLKS_PER_SLOT=16, BLANK_CLKS=4)
REQ-023 Raw scan:
  - Stimulus: Enable=1, LUT=0, Brightness=15, segs 0x01/0x02/0x04.
  - Response: En cycles 001,010,100; each digit dark 4 cycles then lit 12; FrameDone pulses every 48 cycles.
REQ-024 PWM:
  - Stimulus: Brightness=3.
  - Response: within DRIVE, En high 4 cycles, low 8 cycles; Led steady throughout.
REQ-025 Snapshot:
  - Stimulus: change i_SegTwo mid-frame during digit 0.
  - Response: old value shown on digit 1 this frame, new value next frame.
REQ-026 Hex LUT (macro defined):
  - Stimulus: LUT=1, i_SegOne=0x0A.
  - Response: digit 0 Led=0x77.
  - Macro undefined: Led=0x0A.
REQ-027 Abort and reset:
  - Stimulus: Enable dropped during digit 1 DRIVE.
  - Response: outputs 0 within 2 cycles, no FrameDone, restart at digit 0.
  - Stimulus: async i_Rst mid-DRIVE.
  - Response: outputs 0 before the next edge.
